ste_shift_feeder: RTL and testbench

Upstream driver for the ste_shift_reg shift register. It accepts SHIFT_W-bit words over a valid/ready handshake. For each word it either serialises the word MSB-first onto din/shift_en, or issues a one-cycle parallel load, then inserts a programmable idle gap. It also sequences shift-register clears, including aborting a word in flight, and counts completed words.

---
 rtl/ste_shift_feeder.sv | 162 ++++++++++++++++
 tb/tb_ste_shift_feeder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ste_shift_feeder.sv
// Upstream feeder for ste_shift_reg: takes words over valid/ready and either shifts
// them out MSB-first or parallel-loads them, then idles for GAP_CYC cycles.
module ste_shift_feeder #(
    parameter int SHIFT_W = 24,
    parameter int GAP_CYC = 2,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset_ni,
    input  logic [SHIFT_W-1:0] word_i,
    input  logic               ld_mode_i,
    input  logic               word_valid_i,
    output logic               word_ready_o,
    input  logic               clr_req_i,
    output logic               din_o,
    output logic               shift_en_o,
    output logic               shift_ld_o,
    output logic [SHIFT_W-1:0] din_parallel_o,
    output logic               shift_clr_o,
    output logic               busy_o,
    output logic               word_done_o,
    output logic [CNT_W-1:0]   word_cnt_o,
    output logic [2:0]         state_o
);

    // Handshake: a word transfers on a rising edge where word_valid_i & word_ready_o
    // are both 1. word_ready_o never depends on word_valid_i; a clear request in the
    // same cycle drops ready, so the offered word stays with the producer.

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        LOAD  = 3'd2,
        GAP   = 3'd3,
        CLEAR = 3'd4
    } state_t;

    localparam int BW = (SHIFT_W > 1) ? $clog2(SHIFT_W) : 1;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [BW-1:0] BIT_TOP = BW'(SHIFT_W - 1);
    localparam logic [GW-1:0] GAP_TOP = GW'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);

    state_t               state_q, state_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic [SHIFT_W-1:0]   word_q, word_d;
    logic                 ready_q;
    logic                 done_d;
    logic                 accept;

    logic                 din_q;
    logic                 shift_en_q;
    logic                 shift_ld_q;
    logic [SHIFT_W-1:0]   par_q;
    logic                 clr_q;
    logic                 busy_q;
    logic                 done_q;
    logic [CNT_W-1:0]     cnt_q;

    assign word_ready_o = ready_q & ~clr_req_i;
    assign accept       = word_valid_i & word_ready_o;

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        word_d  = word_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_req_i) begin
                    state_d = CLEAR;
                end else if (accept) begin
                    word_d  = word_i;
                    bit_d   = BIT_TOP;
                    state_d = ld_mode_i ? LOAD : SHIFT;
                end
            end
            SHIFT: begin
                if (clr_req_i) begin
                    state_d = CLEAR;
                end else if (bit_q == '0) begin
                    done_d  = 1'b1;
                    gap_d   = GAP_TOP;
                    state_d = (GAP_CYC > 0) ? GAP : IDLE;
                end else begin
                    bit_d = bit_q - BW'(1);
                end
            end
            LOAD: begin
                if (clr_req_i) begin
                    state_d = CLEAR;
                end else begin
                    done_d  = 1'b1;
                    gap_d   = GAP_TOP;
                    state_d = (GAP_CYC > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (clr_req_i) begin
                    state_d = CLEAR;
                end else if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            CLEAR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so each strobe lines up with the
    // cycle its state is occupied.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= IDLE;
            bit_q      <= '0;
            gap_q      <= '0;
            word_q     <= '0;
            ready_q    <= 1'b0;
            din_q      <= 1'b0;
            shift_en_q <= 1'b0;
            shift_ld_q <= 1'b0;
            par_q      <= '0;
            clr_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            bit_q      <= bit_d;
            gap_q      <= gap_d;
            word_q     <= word_d;
            ready_q    <= (state_d == IDLE);
            din_q      <= (state_d == SHIFT) ? word_d[bit_d] : 1'b0;
            shift_en_q <= (state_d == SHIFT);
            shift_ld_q <= (state_d == LOAD);
            par_q      <= (state_d == LOAD) ? word_d : '0;
            clr_q      <= (state_d == CLEAR);
            busy_q     <= (state_d != IDLE);
            done_q     <= done_d;
            if (done_d) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign din_o          = din_q;
    assign shift_en_o     = shift_en_q;
    assign shift_ld_o     = shift_ld_q;
    assign din_parallel_o = par_q;
    assign shift_clr_o    = clr_q;
    assign busy_o         = busy_q;
    assign word_done_o    = done_q;
    assign word_cnt_o     = cnt_q;
    assign state_o        = state_q;

    strobe_onehot: assert property (@(posedge clk) disable iff (!reset_ni)
        $onehot0({shift_en_o, shift_ld_o, shift_clr_o}));

endmodule

// File: tb/tb_ste_shift_feeder.sv
// Self-checking bench for ste_shift_feeder: directed scenarios plus random traffic,
// checked against a cycle-timeline model and a downstream shift-register model.
module tb_ste_shift_feeder;

    localparam int W   = 24;
    localparam int GAP = 2;
    localparam int CW  = 2;

    logic          clk = 1'b0;
    logic          reset_ni = 1'b0;
    logic [W-1:0]  word_i = '0;
    logic          ld_mode_i = 1'b0;
    logic          word_valid_i = 1'b0;
    logic          clr_req_i = 1'b0;
    logic          word_ready_o;
    logic          din_o;
    logic          shift_en_o;
    logic          shift_ld_o;
    logic [W-1:0]  din_parallel_o;
    logic          shift_clr_o;
    logic          busy_o;
    logic          word_done_o;
    logic [CW-1:0] word_cnt_o;
    logic [2:0]    state_o;

    ste_shift_feeder #(.SHIFT_W(W), .GAP_CYC(GAP), .CNT_W(CW)) dut (
        .clk(clk), .reset_ni(reset_ni), .word_i(word_i), .ld_mode_i(ld_mode_i),
        .word_valid_i(word_valid_i), .word_ready_o(word_ready_o), .clr_req_i(clr_req_i),
        .din_o(din_o), .shift_en_o(shift_en_o), .shift_ld_o(shift_ld_o),
        .din_parallel_o(din_parallel_o), .shift_clr_o(shift_clr_o), .busy_o(busy_o),
        .word_done_o(word_done_o), .word_cnt_o(word_cnt_o), .state_o(state_o)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc_n = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    // reference model: timeline of the in-flight word and the clear pulse
    int           rdy_at = 0, idle_at = 0, clr_at = -1, done_at = -1;
    int           first_c = 0, last_c = -1;
    bit           fl = 0, m_ld = 0;
    logic [W-1:0] m_word = '0;
    int           m_cnt = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] sr = '0;
    bit           acc_now = 0;
    int           acc_cyc = 0, done_cyc = 0;
    int           se_total = 0, clr_total = 0;

    task automatic step(input bit v, input logic [W-1:0] w, input bit l, input bit cl);
        logic         e_se, e_din, e_ld, e_clr, e_done, e_busy, e_rdy;
        logic [W-1:0] e_par, sr_n;
        e_se   = fl && !m_ld && cyc_n >= first_c && cyc_n <= last_c;
        e_din  = e_se ? m_word[W-1-(cyc_n-first_c)] : 1'b0;
        e_ld   = fl && m_ld && cyc_n == first_c;
        e_par  = e_ld ? m_word : '0;
        e_clr  = (cyc_n == clr_at);
        e_done = (cyc_n == done_at);
        e_busy = (cyc_n < idle_at);
        if (e_done) m_cnt = (m_cnt + 1) % (1 << CW);
        check("din", din_o, e_din);
        check("shift_en", shift_en_o, e_se);
        check("shift_ld", shift_ld_o, e_ld);
        check("din_parallel", din_parallel_o, e_par);
        check("shift_clr", shift_clr_o, e_clr);
        check("busy", busy_o, e_busy);
        check("word_done", word_done_o, e_done);
        check("word_cnt", word_cnt_o, m_cnt);
        if (e_done && exp_q.size() > 0) check("downstream_word", sr, exp_q.pop_front());
        if (clr_at >= 0 && cyc_n == clr_at + 1) check("downstream_cleared", sr, '0);
        if (shift_en_o) se_total++;
        if (shift_clr_o) clr_total++;
        if (word_done_o) done_cyc = cyc_n;
        if (shift_clr_o)      sr_n = '0;
        else if (shift_ld_o)  sr_n = din_parallel_o;
        else if (shift_en_o)  sr_n = {sr[W-2:0], din_o};
        else                  sr_n = sr;
        // driver
        word_valid_i = v; word_i = w; ld_mode_i = l; clr_req_i = cl;
        #1;
        e_rdy = (cyc_n >= rdy_at) && !cl;
        check("word_ready", word_ready_o, e_rdy);
        acc_now = 0;
        if (cl && cyc_n != clr_at) begin
            if (fl && cyc_n <= last_c) begin
                done_at = -1;
                void'(exp_q.pop_back());
            end
            fl = 0;
            clr_at = cyc_n + 1;
            idle_at = cyc_n + 2;
            rdy_at = cyc_n + 2;
        end else if (e_rdy && v) begin
            acc_now = 1; acc_cyc = cyc_n;
            fl = 1; m_ld = l; m_word = w;
            first_c = cyc_n + 1;
            last_c  = cyc_n + (l ? 1 : W);
            done_at = last_c + 1;
            idle_at = done_at + GAP;
            rdy_at  = idle_at;
            exp_q.push_back(w);
        end
        @(posedge clk);
        sr = sr_n;
        #1;
        cyc_n++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic send(input logic [W-1:0] w, input bit l);
        int n = 0;
        do begin
            step(1'b1, w, l, 1'b0);
            n++;
        end while (!acc_now && n < 100);
        check("send_accept_timeout", acc_now, 1'b1);
        word_valid_i = 1'b0;
    endtask

    // asserts reset mid-cycle, checks outputs dropped without a clock edge
    task automatic apply_reset(input int hold);
        #2;
        word_valid_i = 1'b0; clr_req_i = 1'b0;
        reset_ni = 1'b0;
        #1;
        check("rst_din", din_o, 1'b0);
        check("rst_shift_en", shift_en_o, 1'b0);
        check("rst_shift_ld", shift_ld_o, 1'b0);
        check("rst_din_parallel", din_parallel_o, '0);
        check("rst_shift_clr", shift_clr_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_word_done", word_done_o, 1'b0);
        check("rst_word_cnt", word_cnt_o, '0);
        check("rst_word_ready", word_ready_o, 1'b0);
        repeat (hold) @(posedge clk);
        #1;
        reset_ni = 1'b1;
        cyc_n += hold + 1;
        fl = 0; done_at = -1; clr_at = -1; m_cnt = 0;
        exp_q.delete();
        idle_at = cyc_n;
        rdy_at  = cyc_n + 1;
    endtask

    int a1, c5;
    int exp_seq[5] = '{1, 2, 3, 0, 1};

    initial begin
        apply_reset(3);

        // serial word after reset release
        se_total = 0;
        send(24'hA5AA5A, 1'b0);
        idle(30);
        check("t1_shift_len", se_total, 24);
        check("t1_done_lat", done_cyc - acc_cyc, 25);
        check("t1_cnt", word_cnt_o, 1);

        // back-to-back serial words with valid held
        send(24'h000001, 1'b0);
        a1 = acc_cyc;
        send(24'hFFFFFF, 1'b0);
        check("t2_spacing", acc_cyc - a1, 27);
        idle(30);
        check("t2_downstream", sr, 24'hFFFFFF);
        check("t2_cnt", word_cnt_o, 3);

        // parallel load
        se_total = 0;
        send(24'h234567, 1'b1);
        idle(6);
        check("t3_no_shift", se_total, 0);
        check("t3_done_lat", done_cyc - acc_cyc, 2);
        check("t3_downstream", sr, 24'h234567);

        // clear abort after 10 shift cycles
        se_total = 0;
        send(24'hDFEABC, 1'b0);
        idle(9);
        step(1'b0, '0, 1'b0, 1'b1);
        idle(30);
        check("t4_shift_len", se_total, 10);
        check("t4_cnt", word_cnt_o, 0);
        check("t4_downstream", sr, '0);

        // clear and valid together in IDLE
        c5 = cyc_n;
        step(1'b1, 24'h13579B, 1'b0, 1'b1);
        send(24'h13579B, 1'b0);
        check("t5_accept", acc_cyc - c5, 2);
        idle(30);

        // held clear: CLEAR/IDLE alternation
        clr_total = 0;
        repeat (6) step(1'b1, 24'h111111, 1'b0, 1'b1);
        check("held_clr_pulses", clr_total, 3);
        idle(4);

        // reset mid-word, then counter wrap
        send(24'hC0FFEE, 1'b0);
        idle(5);
        apply_reset(2);
        for (int i = 0; i < 5; i++) begin
            send(W'($urandom), 1'(i % 2));
            idle(30);
            check("t6_cnt", word_cnt_o, exp_seq[i]);
        end

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 1)), W'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0));
        end
        idle(30);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
